bi_mem_arbiter: RTL and testbench
=================================

Name: bi_mem_arbiter

Overview:
- Shares one single-port memory interface (enable/isWrite/mask/addr/data/hold style, 1-cycle read latency) between NUM_REQ requesters of identical width.
- Grants are round-robin and combinational: the winner's request drives the memory in the same cycle.
- Read data is broadcast to all requesters; a per-requester valid strobe marks the owner.
- Sits directly in front of a memory macro or a width converter; requesters see the standard hold handshake.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_SIZE, 32, data width.
- ADDR_SIZE, 8, address width.
- MASK_SIZE, 4, write-mask width (DATA_SIZE % MASK_SIZE == 0).
- IDX_BITS, $clog2(NUM_REQ), derived localparam, index width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- useEnable_i  in  NUM_REQ  request per requester.
- useIsWrite_i  in  NUM_REQ  write flag per requester.
- useWriteMask_i  in  NUM_REQ*MASK_SIZE  packed masks; requester k at [k*MASK_SIZE+:MASK_SIZE].
- useAddr_i  in  NUM_REQ*ADDR_SIZE  packed addresses.
- useWriteData_i  in  NUM_REQ*DATA_SIZE  packed write data.
- useReadData_o  out  DATA_SIZE  broadcast read data (memReadData_i passthrough).
- useReadValid_o  out  NUM_REQ  one-hot: read data belongs to requester k this cycle.
- useHold_o  out  NUM_REQ  per-requester stall.
- memEnable_o  out  1  memory request.
- memIsWrite_o  out  1  memory write flag.
- memWriteMask_o  out  MASK_SIZE  memory write mask.
- memAddr_o  out  ADDR_SIZE  memory address.
- memWriteData_o  out  DATA_SIZE  memory write data.
- memReadData_i  in  DATA_SIZE  memory read data, valid the cycle after accept.
- memHold_i  in  1  memory stall.

Behaviour:
- State registers:
  - rrPtr (IDX_BITS): highest-priority requester.
  - rdValid (1).
  - rdOwner (IDX_BITS).
- Reset (rst_ni low, async):
  - rrPtr=0, rdValid=0, rdOwner=0.
  - While reset is asserted, outputs are forced: memEnable_o=0, useHold_o='1, useReadValid_o=0.
- Grant selection (combinational):
  - Winner is the first k with useEnable_i[k]=1, scanning rrPtr, rrPtr+1, …, wrapping modulo NUM_REQ.
  - No active request: memEnable_o=0; mask/addr/data/isWrite outputs are 0.
- Memory side: winner's isWrite/mask/addr/data are muxed to the mem outputs; memEnable_o=1.
- Acceptance:
  - A request is accepted in a cycle where memEnable_o=1 and memHold_i=0.
  - useHold_o[k]=1 for every k with useEnable_i[k]=1 that is not an accepted winner.
  - Requesters must hold their request stable while held.
  - Idle requesters see useHold_o[k]=memHold_i.
- rrPtr update: on acceptance, rrPtr <= winner+1 (wrap to 0 after NUM_REQ-1). Otherwise unchanged, so a request stalled by memHold_i keeps its grant next cycle.
- Read return:
  - On accepted read: rdValid<=1, rdOwner<=winner. Otherwise rdValid<=0.
  - useReadValid_o = rdValid ? onehot(rdOwner) : 0.
  - useReadData_o = memReadData_i at all times.
  - Back-to-back reads from different requesters each get their strobe one cycle after their own accept.
- Writes produce no valid strobe.
- memHold_i high: nothing accepted, rdValid<=0 next cycle, all active requesters held.
- Simultaneous requests from all NUM_REQ: each is served exactly once within NUM_REQ accepted cycles.
- Reset mid-read: a pending read strobe is dropped (rdValid cleared asynchronously).

Test Plan:
- Single requester 2 reads @0x10, @0x11 with memHold_i=0 → accepted on consecutive cycles; useReadValid_o=4'b0001 in the cycle after each accept; useHold_o[0]=0.
- All 4 requesters request continuously, rrPtr=0 after reset → grant order 0,1,2,3,0; each useHold_o[k] low exactly on its own grant cycle.
- Requester 2 read in progress while memHold_i=1 for 3 cycles → memAddr_o stable, useHold_o[2]=1 for those cycles, rrPtr stays 2, accept in 4th cycle, strobe 4'b0100 the next cycle.
- Requester 1 write (mask 4'b0011, data 0xDEADBEEF) then requester 3 read → memWriteMask_o=0011, memWriteData_o=0xDEADBEEF in the write cycle; strobe only 4'b1000, one cycle after the read accept.
- rst_ni pulled low during the cycle after an accepted read → useReadValid_o=0 immediately; after release rrPtr=0 and requester 0 wins a tie with requester 3.
- Requesters 0 and 3 active, rrPtr=3 → requester 3 granted first, rrPtr wraps to 0, then requester 0 granted.

Source files
------------

// File: rtl/bi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bi_mem_arbiter
// Purpose  : Shares one single-port memory interface (enable / isWrite /
//            mask / addr / data / hold, 1-cycle read latency) between
//            NUM_REQ requesters. The round-robin grant is combinational, so
//            the winning request drives the memory in the same cycle. Read
//            data is broadcast to all requesters, and a one-hot valid strobe
//            identifies the requester that owns it.
// Ports    :
//   clk_i, rst_ni     - clock, asynchronous active-low reset
//   useEnable_i       - [NUM_REQ] request per requester
//   useIsWrite_i      - [NUM_REQ] write flag per requester
//   useWriteMask_i    - packed masks, requester k at [k*MASK_SIZE +: MASK_SIZE]
//   useAddr_i         - packed addresses, requester k at [k*ADDR_SIZE +: ...]
//   useWriteData_i    - packed write data, requester k at [k*DATA_SIZE +: ...]
//   useReadData_o     - broadcast read data (memReadData_i passthrough)
//   useReadValid_o    - one-hot owner of this cycle's read data
//   useHold_o         - per-requester stall
//   memEnable_o .. memWriteData_o - memory request of the current winner
//   memReadData_i     - memory read data, valid the cycle after accept
//   memHold_i         - memory stall
// Revision : 1.0 - initial release
// ============================================================================
module bi_mem_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 8,
    parameter int MASK_SIZE = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             useEnable_i,
    input  logic [NUM_REQ-1:0]             useIsWrite_i,
    input  logic [NUM_REQ*MASK_SIZE-1:0]   useWriteMask_i,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   useAddr_i,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   useWriteData_i,
    output logic [DATA_SIZE-1:0]           useReadData_o,
    output logic [NUM_REQ-1:0]             useReadValid_o,
    output logic [NUM_REQ-1:0]             useHold_o,
    output logic                           memEnable_o,
    output logic                           memIsWrite_o,
    output logic [MASK_SIZE-1:0]           memWriteMask_o,
    output logic [ADDR_SIZE-1:0]           memAddr_o,
    output logic [DATA_SIZE-1:0]           memWriteData_o,
    input  logic [DATA_SIZE-1:0]           memReadData_i,
    input  logic                           memHold_i
);

    localparam int IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Candidate arithmetic is one bit wider so rrPtr + offset never overflows
    // before the modulo-NUM_REQ fold.
    localparam logic [IDX_BITS:0]   c_num_req  = (IDX_BITS+1)'(NUM_REQ);
    localparam logic [IDX_BITS-1:0] c_last_idx = IDX_BITS'(NUM_REQ - 1);

    logic [IDX_BITS-1:0] r_rr_ptr;
    logic                r_rd_valid;
    logic [IDX_BITS-1:0] r_rd_owner;

    logic [IDX_BITS:0]   w_cand;
    logic [IDX_BITS-1:0] w_winner;
    logic                w_any;
    logic                w_accept;
    logic [IDX_BITS-1:0] w_next_ptr;

    // ------------------------------------------------------------------
    // Round-robin grant. The scan runs from the lowest priority offset to
    // the highest, so the last hit written is the first active requester
    // at or after r_rr_ptr.
    // ------------------------------------------------------------------
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = {1'b0, r_rr_ptr} + (IDX_BITS+1)'(i);
            if (w_cand >= c_num_req) begin
                w_cand = w_cand - c_num_req;
            end
            if (useEnable_i[w_cand[IDX_BITS-1:0]]) begin
                w_any    = 1'b1;
                w_winner = w_cand[IDX_BITS-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory-side mux; all fields read as zero when nobody requests.
    // ------------------------------------------------------------------
    always_comb begin
        memIsWrite_o   = 1'b0;
        memWriteMask_o = '0;
        memAddr_o      = '0;
        memWriteData_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_any && (w_winner == IDX_BITS'(k))) begin
                memIsWrite_o   = useIsWrite_i[k];
                memWriteMask_o = useWriteMask_i[k*MASK_SIZE +: MASK_SIZE];
                memAddr_o      = useAddr_i[k*ADDR_SIZE +: ADDR_SIZE];
                memWriteData_o = useWriteData_i[k*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign memEnable_o = w_any & rst_ni;
    assign w_accept    = w_any & ~memHold_i & rst_ni;
    assign w_next_ptr  = (w_winner == c_last_idx) ? '0 : w_winner + IDX_BITS'(1);

    // ------------------------------------------------------------------
    // Requester-side handshake. An active requester is released only on
    // its own accepted cycle; idle requesters simply mirror memHold_i.
    // ------------------------------------------------------------------
    always_comb begin
        useHold_o      = '1;
        useReadValid_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rst_ni) begin
                useHold_o[k] = 1'b1;
            end else if (useEnable_i[k]) begin
                useHold_o[k] = ~(w_accept && (w_winner == IDX_BITS'(k)));
            end else begin
                useHold_o[k] = memHold_i;
            end
            useReadValid_o[k] = rst_ni && r_rd_valid && (r_rd_owner == IDX_BITS'(k));
        end
    end

    assign useReadData_o = memReadData_i;

    // ------------------------------------------------------------------
    // State: the pointer only moves on acceptance, so a request stalled
    // by memHold_i keeps its grant on the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_owner <= '0;
        end else begin
            r_rd_valid <= w_accept & ~memIsWrite_o;
            if (w_accept) begin
                r_rr_ptr <= w_next_ptr;
                if (!memIsWrite_o) begin
                    r_rd_owner <= w_winner;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bi_mem_arbiter
// Purpose  : Self-checking bench for bi_mem_arbiter (NUM_REQ=4, 32-bit data,
//            8-bit address, 4-bit mask). A vector table drives requests and
//            holds the expected grant and per-requester stalls; read returns
//            are queued when a read is expected to be accepted and compared
//            one cycle later. A hand-written sequence covers reset mid-read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bi_mem_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   en;
    logic [3:0]   wr;
    logic [15:0]  mask;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [31:0]  rdata_o;
    logic [3:0]   rvalid;
    logic [3:0]   uhold;
    logic         men;
    logic         misw;
    logic [3:0]   mmask;
    logic [7:0]   maddr;
    logic [31:0]  mwdata;
    logic [31:0]  mrdata;
    logic         mhold;

    int n_checks = 0;
    int n_err    = 0;

    bi_mem_arbiter #(
        .NUM_REQ  (4),
        .DATA_SIZE(32),
        .ADDR_SIZE(8),
        .MASK_SIZE(4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .useEnable_i   (en),
        .useIsWrite_i  (wr),
        .useWriteMask_i(mask),
        .useAddr_i     (addr),
        .useWriteData_i(wdata),
        .useReadData_o (rdata_o),
        .useReadValid_o(rvalid),
        .useHold_o     (uhold),
        .memEnable_o   (men),
        .memIsWrite_o  (misw),
        .memWriteMask_o(mmask),
        .memAddr_o     (maddr),
        .memWriteData_o(mwdata),
        .memReadData_i (mrdata),
        .memHold_i     (mhold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rdata_fn(input logic [7:0] a);
        return {a, ~a, 8'h5A, a ^ 8'hC3};
    endfunction

    // Memory model: 1-cycle read latency, zero when no read was accepted.
    always @(posedge clk) begin
        mrdata <= (men && !mhold && !misw) ? rdata_fn(maddr) : 32'h0;
    end

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  wr;
        logic        hold;
        logic [7:0]  addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        int          win;
        logic [3:0]  exp_hold;
    } vec_t;

    typedef struct {
        logic [3:0]  oh;
        logic [31:0] data;
    } sb_t;

    sb_t  q[$];
    vec_t vec[21];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // The expected winner gets the table fields; every other requester gets
    // distinct values so a wrong mux selection is visible.
    task automatic drive(input vec_t v);
        for (int k = 0; k < 4; k++) begin
            en[k] = v.en[k];
            wr[k] = v.wr[k];
            if (k == v.win) begin
                addr[k*8 +: 8]   = v.addr;
                mask[k*4 +: 4]   = v.mask;
                wdata[k*32 +: 32] = v.wdata;
            end else begin
                addr[k*8 +: 8]   = v.addr ^ (8'h80 | 8'(k));
                mask[k*4 +: 4]   = ~v.mask;
                wdata[k*32 +: 32] = v.wdata ^ 32'hFFFF0000 ^ 32'(k);
            end
        end
        mhold = v.hold;
    endtask

    task automatic check(input vec_t v);
        sb_t e;
        logic [3:0] oh;
        if (v.win >= 0) begin
            chk("memEnable", {63'h0, men}, 64'h1);
            chk("memIsWrite", {63'h0, misw}, {63'h0, v.wr[v.win]});
            chk("memWriteMask", {60'h0, mmask}, {60'h0, v.mask});
            chk("memAddr", {56'h0, maddr}, {56'h0, v.addr});
            chk("memWriteData", {32'h0, mwdata}, {32'h0, v.wdata});
        end else begin
            chk("memEnable_idle", {63'h0, men}, 64'h0);
            chk("memFields_idle", {misw, mmask, maddr, mwdata}, 64'h0);
        end
        chk("useHold", {60'h0, uhold}, {60'h0, v.exp_hold});
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("readValid", {60'h0, rvalid}, {60'h0, e.oh});
            chk("readData", {32'h0, rdata_o}, {32'h0, e.data});
        end else begin
            chk("readValid_none", {60'h0, rvalid}, 64'h0);
        end
        if (v.win >= 0 && !v.hold && !v.wr[v.win]) begin
            oh = 4'b0001 << v.win;
            q.push_back('{oh, rdata_fn(v.addr)});
        end
    endtask

    initial begin
        vec_t va;
        sb_t  e;
        // en, wr, hold, addr, mask, wdata, win, exp_hold
        vec[0]  = '{4'b1111, 4'b0000, 1'b0, 8'h20, 4'hF, 32'h0000_0000,  0, 4'b1110};
        vec[1]  = '{4'b1111, 4'b0000, 1'b0, 8'h21, 4'hF, 32'h0000_0000,  1, 4'b1101};
        vec[2]  = '{4'b1111, 4'b0000, 1'b0, 8'h22, 4'hF, 32'h0000_0000,  2, 4'b1011};
        vec[3]  = '{4'b1111, 4'b0000, 1'b0, 8'h23, 4'hF, 32'h0000_0000,  3, 4'b0111};
        vec[4]  = '{4'b1111, 4'b0000, 1'b0, 8'h24, 4'hF, 32'h0000_0000,  0, 4'b1110};
        vec[5]  = '{4'b0001, 4'b0000, 1'b0, 8'h10, 4'hF, 32'h0000_0000,  0, 4'b0000};
        vec[6]  = '{4'b0001, 4'b0000, 1'b0, 8'h11, 4'hF, 32'h0000_0000,  0, 4'b0000};
        vec[7]  = '{4'b0010, 4'b0000, 1'b0, 8'h30, 4'hF, 32'h0000_0000,  1, 4'b0000};
        vec[8]  = '{4'b0100, 4'b0000, 1'b1, 8'h40, 4'hF, 32'h0000_0000,  2, 4'b1111};
        vec[9]  = '{4'b0100, 4'b0000, 1'b1, 8'h40, 4'hF, 32'h0000_0000,  2, 4'b1111};
        vec[10] = '{4'b0100, 4'b0000, 1'b1, 8'h40, 4'hF, 32'h0000_0000,  2, 4'b1111};
        vec[11] = '{4'b0100, 4'b0000, 1'b0, 8'h40, 4'hF, 32'h0000_0000,  2, 4'b0000};
        vec[12] = '{4'b0010, 4'b0010, 1'b0, 8'h50, 4'h3, 32'hDEAD_BEEF,  1, 4'b0000};
        vec[13] = '{4'b1000, 4'b0000, 1'b0, 8'h60, 4'hF, 32'h0000_0000,  3, 4'b0000};
        vec[14] = '{4'b0100, 4'b0000, 1'b0, 8'h70, 4'hF, 32'h0000_0000,  2, 4'b0000};
        vec[15] = '{4'b1001, 4'b0000, 1'b0, 8'h80, 4'hF, 32'h0000_0000,  3, 4'b0001};
        vec[16] = '{4'b1001, 4'b0000, 1'b0, 8'h81, 4'hF, 32'h0000_0000,  0, 4'b1000};
        vec[17] = '{4'b0000, 4'b0000, 1'b0, 8'h00, 4'hF, 32'h0000_0000, -1, 4'b0000};
        vec[18] = '{4'b0000, 4'b0000, 1'b1, 8'h00, 4'hF, 32'h0000_0000, -1, 4'b1111};
        vec[19] = '{4'b0110, 4'b0000, 1'b1, 8'h90, 4'hF, 32'h1234_5678,  1, 4'b1111};
        vec[20] = '{4'b0000, 4'b0000, 1'b0, 8'h00, 4'hF, 32'h0000_0000, -1, 4'b0000};

        // Reset state with every requester active.
        rst_n = 1'b0;
        en = 4'b1111; wr = 4'b0000; mask = '0; addr = '0; wdata = '0; mhold = 1'b0;
        #2;
        chk("rst_memEnable", {63'h0, men}, 64'h0);
        chk("rst_useHold", {60'h0, uhold}, 64'hF);
        chk("rst_readValid", {60'h0, rvalid}, 64'h0);
        @(posedge clk); #1;
        chk("rst_readValid_clk", {60'h0, rvalid}, 64'h0);
        en = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 21; i++) begin
            drive(vec[i]);
            @(negedge clk);
            check(vec[i]);
            @(posedge clk); #1;
        end

        // Reset asserted in the cycle after an accepted read.
        va = '{4'b0010, 4'b0000, 1'b0, 8'h90, 4'hF, 32'h0, 1, 4'b0000};
        drive(va);
        @(negedge clk);
        check(va);
        @(posedge clk); #1;
        e = q.pop_front();
        chk("pre_rst_readValid", {60'h0, rvalid}, {60'h0, e.oh});
        chk("pre_rst_readData", {32'h0, rdata_o}, {32'h0, e.data});
        rst_n = 1'b0;
        #1;
        chk("midrst_readValid", {60'h0, rvalid}, 64'h0);
        chk("midrst_memEnable", {63'h0, men}, 64'h0);
        chk("midrst_useHold", {60'h0, uhold}, 64'hF);
        va = '{4'b1001, 4'b0000, 1'b0, 8'hA0, 4'hF, 32'h0, 0, 4'b1000};
        drive(va);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check(va);
        @(posedge clk); #1;
        va = '{4'b0000, 4'b0000, 1'b0, 8'h00, 4'hF, 32'h0, -1, 4'b0000};
        drive(va);
        @(negedge clk);
        check(va);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
